// File: rtl/decoder_pkg.sv
// Shared decode encodings for the MIPS-subset ID stage: opcodes, functs, ALU classes and the control word.
// Used by decode_comb and pipelined_decoder (load-use interlock selectable with DECODER_LOADUSE_EN).
package decoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [3:0] {
        ALU_RTYPE = 4'd0,
        ALU_ADDI  = 4'd1,
        ALU_SLTIU = 4'd2,
        ALU_BEQ   = 4'd3,
        ALU_LUI   = 4'd4,
        ALU_ORI   = 4'd5,
        ALU_BNE   = 4'd6,
        ALU_LW    = 4'd7,
        ALU_SW    = 4'd8,
        ALU_BLEZ  = 4'd9,
        ALU_BGTZ  = 4'd10,
        ALU_JR    = 4'd11,
        ALU_J     = 4'd12,
        ALU_JAL   = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_REG  = 2'd0,
        SRC_IMM  = 2'd1,
        SRC_ZERO = 2'd2
    } alu_src_e;

    typedef enum logic [1:0] {
        JC_NONE = 2'd0,
        JC_JR   = 2'd1,
        JC_JAL  = 2'd2
    } jump_ctrl_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       branch;
        logic       branch_eq;
        logic       jump;
        alu_op_e    alu_op;
        alu_src_e   alu_src;
        jump_ctrl_e jump_ctrl;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = ctrl_word_t'(15'd0);

    // Instructions whose rt field is a source operand (the rest only write rt or ignore it).
    function automatic logic op_uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decode: control word, register indices, final destination,
// extended immediate and illegal-encoding flag.
module decode_comb
    import decoder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output ctrl_word_t      ctrl_o,
    output logic [4:0]      rs_o,
    output logic [4:0]      rt_o,
    output logic [4:0]      dest_o,
    output logic [XLEN-1:0] imm_o,
    output logic            uses_rt_o,
    output logic            illegal_o
);

    logic [5:0]      opcode_s;
    logic [5:0]      funct_s;
    logic [4:0]      rd_field_s;
    logic [XLEN-1:0] imm_sext_s;
    logic [XLEN-1:0] imm_zext_s;
    logic [XLEN-1:0] imm_lui_s;
    logic [XLEN-1:0] imm_jump_s;
    logic            unused_shamt_s;

    assign opcode_s       = instr_i[31:26];
    assign funct_s        = instr_i[5:0];
    assign rd_field_s     = instr_i[15:11];
    assign rs_o           = instr_i[25:21];
    assign rt_o           = instr_i[20:16];
    assign imm_sext_s     = {{(XLEN-16){instr_i[15]}}, instr_i[15:0]};
    assign imm_zext_s     = {{(XLEN-16){1'b0}}, instr_i[15:0]};
    assign imm_lui_s      = XLEN'({instr_i[15:0], 16'h0000});
    assign imm_jump_s     = {{(XLEN-26){1'b0}}, instr_i[25:0]};
    assign uses_rt_o      = op_uses_rt(opcode_s);
    assign unused_shamt_s = ^instr_i[10:6];

    // Opcode/funct decode; illegal paths simply never raise any enable.
    always_comb begin
        ctrl_o    = CTRL_NOP;
        imm_o     = {XLEN{1'b0}};
        dest_o    = instr_i[20:16];
        illegal_o = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                ctrl_o.reg_dst = 1'b1;
                dest_o         = rd_field_s;
                case (funct_s)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL: begin
                        ctrl_o.reg_write = 1'b1;
                    end
                    F_JR: begin
                        ctrl_o.alu_op    = ALU_JR;
                        ctrl_o.jump      = 1'b1;
                        ctrl_o.jump_ctrl = JC_JR;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_ADDI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_ADDI;
                ctrl_o.alu_src   = SRC_IMM;
                imm_o            = imm_sext_s;
            end
            OP_SLTIU: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_SLTIU;
                ctrl_o.alu_src   = SRC_IMM;
                imm_o            = imm_sext_s;
            end
            OP_BEQ: begin
                ctrl_o.branch    = 1'b1;
                ctrl_o.branch_eq = 1'b1;
                ctrl_o.alu_op    = ALU_BEQ;
                imm_o            = imm_sext_s;
            end
            OP_LUI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_LUI;
                ctrl_o.alu_src   = SRC_IMM;
                imm_o            = imm_lui_s;
            end
            OP_ORI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_ORI;
                ctrl_o.alu_src   = SRC_IMM;
                imm_o            = imm_zext_s;
            end
            OP_BNE: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.alu_op = ALU_BNE;
                imm_o         = imm_sext_s;
            end
            OP_LW: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_op    = ALU_LW;
                ctrl_o.alu_src   = SRC_IMM;
                imm_o            = imm_sext_s;
            end
            OP_SW: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_op    = ALU_SW;
                ctrl_o.alu_src   = SRC_IMM;
                imm_o            = imm_sext_s;
            end
            OP_BLEZ: begin
                ctrl_o.branch  = 1'b1;
                ctrl_o.alu_op  = ALU_BLEZ;
                ctrl_o.alu_src = SRC_ZERO;
                imm_o          = imm_sext_s;
            end
            OP_BGTZ: begin
                ctrl_o.branch  = 1'b1;
                ctrl_o.alu_op  = ALU_BGTZ;
                ctrl_o.alu_src = SRC_ZERO;
                imm_o          = imm_sext_s;
            end
            OP_J: begin
                ctrl_o.jump   = 1'b1;
                ctrl_o.alu_op = ALU_J;
                imm_o         = imm_jump_s;
            end
            OP_JAL: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.jump      = 1'b1;
                ctrl_o.alu_op    = ALU_JAL;
                ctrl_o.jump_ctrl = JC_JAL;
                dest_o           = REG_RA;
                imm_o            = imm_jump_s;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_decoder.sv
// ID stage with ID/EX output register, valid/ready handshake, flush and load-use bubble insertion.
// Define DECODER_LOADUSE_EN to enable the load-use interlock; otherwise software must schedule NOPs.
module pipelined_decoder
    import decoder_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        instr_i,
    input  logic               instr_valid_i,
    output logic               id_ready_o,
    input  logic               flush_i,
    input  logic               ex_ready_i,
    output logic               valid_o,
    output logic               RegWrite_o,
    output logic               memread_o,
    output logic               memwrite_o,
    output logic               RegDst_o,
    output logic               Branch_o,
    output logic               Branch_eq,
    output logic               Jump_o,
    output logic [ALUOP_W-1:0] ALU_op_o,
    output logic [1:0]         ALUSrc_o,
    output logic [1:0]         Jump_Ctrl_o,
    output logic [REG_AW-1:0]  rs_o,
    output logic [REG_AW-1:0]  rt_o,
    output logic [REG_AW-1:0]  rd_o,
    output logic [XLEN-1:0]    imm_o,
    output logic               illegal_o
);

    ctrl_word_t      dec_ctrl_s;
    logic [4:0]      dec_rs_s;
    logic [4:0]      dec_rt_s;
    logic [4:0]      dec_dest_s;
    logic [XLEN-1:0] dec_imm_s;
    logic            dec_uses_rt_s;
    logic            dec_illegal_s;

    logic            load_en_s;
    logic            hazard_s;
    logic            take_s;

    logic              valid_q,   valid_d;
    ctrl_word_t        ctrl_q,    ctrl_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic [REG_AW-1:0] rd_q,      rd_d;
    logic [XLEN-1:0]   imm_q,     imm_d;
    logic              illegal_q, illegal_d;

    decode_comb #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i   (instr_i),
        .ctrl_o    (dec_ctrl_s),
        .rs_o      (dec_rs_s),
        .rt_o      (dec_rt_s),
        .dest_o    (dec_dest_s),
        .imm_o     (dec_imm_s),
        .uses_rt_o (dec_uses_rt_s),
        .illegal_o (dec_illegal_s)
    );

    assign load_en_s = !valid_q || ex_ready_i;

`ifdef DECODER_LOADUSE_EN
    // A load in ID/EX whose target feeds the incoming instruction must wait one cycle.
    assign hazard_s = valid_q && ctrl_q.mem_read && instr_valid_i
                      && ((rd_q == REG_AW'(dec_rs_s))
                          || (dec_uses_rt_s && (rd_q == REG_AW'(dec_rt_s))))
                      && (rd_q != {REG_AW{1'b0}});
`else
    logic unused_uses_rt_s;
    assign hazard_s         = 1'b0;
    assign unused_uses_rt_s = dec_uses_rt_s;
`endif

    assign take_s     = instr_valid_i && !hazard_s;
    assign id_ready_o = rst_i || flush_i || (load_en_s && !hazard_s);

    // Next-state of the ID/EX register: flush or bubble clears it, load captures decode, else hold.
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        illegal_d = illegal_q;
        if (flush_i || (load_en_s && !take_s)) begin
            valid_d   = 1'b0;
            ctrl_d    = CTRL_NOP;
            rs_d      = {REG_AW{1'b0}};
            rt_d      = {REG_AW{1'b0}};
            rd_d      = {REG_AW{1'b0}};
            imm_d     = {XLEN{1'b0}};
            illegal_d = 1'b0;
        end else if (load_en_s) begin
            valid_d   = 1'b1;
            ctrl_d    = dec_ctrl_s;
            rs_d      = REG_AW'(dec_rs_s);
            rt_d      = REG_AW'(dec_rt_s);
            rd_d      = REG_AW'(dec_dest_s);
            imm_d     = dec_imm_s;
            illegal_d = dec_illegal_s;
        end else begin
            valid_d   = valid_q;
        end
    end

    // ID/EX pipeline register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_NOP;
            rs_q      <= {REG_AW{1'b0}};
            rt_q      <= {REG_AW{1'b0}};
            rd_q      <= {REG_AW{1'b0}};
            imm_q     <= {XLEN{1'b0}};
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
        end
    end

    assign valid_o     = valid_q;
    assign RegWrite_o  = ctrl_q.reg_write;
    assign memread_o   = ctrl_q.mem_read;
    assign memwrite_o  = ctrl_q.mem_write;
    assign RegDst_o    = ctrl_q.reg_dst;
    assign Branch_o    = ctrl_q.branch;
    assign Branch_eq   = ctrl_q.branch_eq;
    assign Jump_o      = ctrl_q.jump;
    assign ALU_op_o    = ALUOP_W'(ctrl_q.alu_op);
    assign ALUSrc_o    = ctrl_q.alu_src;
    assign Jump_Ctrl_o = ctrl_q.jump_ctrl;
    assign rs_o        = rs_q;
    assign rt_o        = rt_q;
    assign rd_o        = rd_q;
    assign imm_o       = imm_q;
    assign illegal_o   = illegal_q;

endmodule

// File: doc/pipelined_decoder.md
Name: pipelined_decoder

Overview:
- Registered instruction-decode stage for the MIPS-subset core: decodes opcode/funct into a control word plus register indices and an extended immediate.
- Holds the result in an ID/EX pipeline register with a valid/ready handshake on both sides.
- Detects load-use hazards and inserts bubbles; accepts a flush from branch/jump resolution.
- Generalises the single-cycle decoder to parametrised datapath width with jr/jal/blez/bgtz/lw/sw fully decoded.

Parameters:
- XLEN, 32, datapath width of imm_o; must be >= 32.
- REG_AW, 5, register index width.
- ALUOP_W, 4, width of ALU_op_o.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_i  in  32  instruction from IF
- instr_valid_i  in  1  instr_i is valid
- id_ready_o  out  1  stage accepts instr_i this cycle
- flush_i  in  1  squash instruction in decode and in output register
- ex_ready_i  in  1  EX consumes the output register this cycle
- valid_o  out  1  output register holds a real instruction
- RegWrite_o, memread_o, memwrite_o, RegDst_o, Branch_o, Branch_eq, Jump_o  out  1 each  control bits
- ALU_op_o  out  ALUOP_W  ALU operation class
- ALUSrc_o  out  2  0 = rt register, 1 = immediate, 2 = constant zero
- Jump_Ctrl_o  out  2  0 = none/pseudo-direct, 1 = jr (register), 2 = jal (link)
- rs_o, rt_o, rd_o  out  REG_AW each  rd_o is the final destination (rd, rt, or 31 for jal)
- imm_o  out  XLEN  extended immediate
- illegal_o  out  1  unknown opcode or funct

Behaviour:
- Reset: every output register is 0, including valid_o. id_ready_o is combinational, so it is 1 during reset.
- Opcode decode:
  - 000000 R_TYPE=0; funct 001000 gives jr: ALU_op=11, Jump_o=1, Jump_Ctrl=1, RegWrite=0.
  - 001000 ADDI=1; 001011 SLTIU=2; 000100 BEQ=3; 001111 LUI=4; 001101 ORI=5; 000101 BNE=6.
  - 100011 LW=7; 101011 SW=8; 000110 BLEZ=9; 000111 BGTZ=10.
  - 000010 J=12; 000011 JAL=13 (RegWrite=1, rd_o=31, Jump_Ctrl=2).
- Control fields:
  - ALUSrc = 1 for addi, sltiu, lui, ori, lw, sw; 2 for blez, bgtz; 0 otherwise.
  - RegWrite = 1 for R-type except jr, addi, sltiu, lui, ori, lw, jal.
  - Branch_o = 1 for beq, bne, blez, bgtz; Branch_eq = 1 only for beq.
  - RegDst_o = 1 for R-type.
  - Destination: rd_o = instr[15:11] if R-type, 31 if jal, else instr[20:16].
- Immediate:
  - Sign-extend instr[15:0] for addi, sltiu, lw, sw, and all branches.
  - Zero-extend for ori.
  - lui: instr[15:0] << 16, upper bits 0.
  - j/jal: zero-extended instr[25:0].
  - Otherwise 0.
- Illegal encodings: unknown opcode, or R-type funct not in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll, 000010 srl, 001000 jr}.
  - illegal_o = 1; RegWrite, memread, memwrite, Branch and Jump are all 0; valid_o still 1.
- Handshake:
  - load_en = !valid_o || ex_ready_i.
  - hazard = valid_o && memread_o && instr_valid_i && (rd_o == rs(instr_i) || (uses_rt(instr_i) && rd_o == rt(instr_i))) && rd_o != 0.
  - uses_rt: R-type, beq, bne, sw.
  - id_ready_o = load_en && !hazard.
  - On load_en, the output register loads the decode of instr_i and valid_o <= instr_valid_i && !hazard. A hazard therefore loads a bubble (valid_o = 0, all enables 0).
  - If !load_en, the output register holds all fields unchanged.
- Flush: highest priority after reset.
  - valid_o <= 0 and all enables <= 0 next cycle.
  - id_ready_o = 1 during flush; the incoming instruction is consumed and discarded.
- Latency: 1 cycle from accepted instr_i to valid_o.
- A load-use hazard costs exactly one bubble cycle.

Optional Feature:
- Macro DECODER_LOADUSE_EN.
- Defined: hazard detection and bubble insertion as above.
- Undefined: hazard is tied to 0; id_ready_o = load_en, and software supplies the NOPs.

Decomposition:
- Package decoder_pkg:
  - opcode and funct localparams;
  - ALU_op encodings 0–13;
  - ALUSrc codes (REG, IMM, ZERO);
  - Jump_Ctrl codes (NONE, JR, JAL);
  - packed ctrl_word typedef.
- One combinational sub-module, decode_comb: instr → ctrl_word, rs, rt, dest, imm, illegal. pipelined_decoder adds the pipeline register, handshake, hazard logic and flush.

Test Plan:
- Reset held 2 cycles, then addi $8,$9,-1 (0x2128FFFF) with ex_ready=1 → next cycle valid_o=1, ALU_op=1, ALUSrc=1, RegWrite=1, rd_o=8, imm_o=0xFFFFFFFF.
- lw $8,0($9), then add $10,$8,$11 → add stalls 1 cycle (id_ready_o=0, bubble valid_o=0), then issues with ALU_op=0, rd_o=10. Without DECODER_LOADUSE_EN: no stall.
- lw $0,0($9), then add $10,$0,$11 → no stall.
- jal 0x0000040 → ALU_op=13, Jump_o=1, Jump_Ctrl=2, RegWrite=1, rd_o=31, imm_o=0x40. jr $31 (0x03E00008) → Jump_Ctrl=1, RegWrite=0.
- ex_ready=0 for 3 cycles holding ori $4,$4,0x8000 → outputs stable, id_ready_o=0, imm_o=0x00008000. Then flush_i=1 → next cycle valid_o=0.
- Opcode 111111 → illegal_o=1, valid_o=1, all write enables 0. lui $2,0x1234 → imm_o=0x12340000.
